// File: rtl/control_unit.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXECUTE/MEM/WB and
// decodes opcode/funct3/funct7 into datapath selects and write enables.
module control_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] alu_result,
   output logic [2:0]  mux_se,
   output logic        mux_alu,
   output logic        we_alu,
   output logic [3:0]  aluop,
   output logic        we_result,
   output logic        we_dmem,
   output logic        we_pc,
   output logic        we_store,
   output logic [1:0]  mux_store,
   output logic [2:0]  mux_load,
   output logic [2:0]  mux_wb,
   output logic        we_rf,
   output logic        mux_pc,
   output logic        mux_jalr
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_WB
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] se_sel;
   logic       alu_sel;
   logic [3:0] alu_op;
   logic       taken;
   logic       unused_funct7;

   // Only funct7[5] distinguishes SUB/SRA/SRAI; the rest of the field is don't-care.
   assign unused_funct7 = ^{funct7[6], funct7[4:0]};

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // Operand selects and ALU operation, stable from DECODE onward
   always_comb begin
      se_sel  = 3'b000;
      alu_sel = 1'b0;
      alu_op  = ALU_ADD;
      taken   = 1'b0;
      case (opcode)
         OP_OPIMM, OP_LOAD, OP_JALR: alu_sel = 1'b1;
         OP_STORE: begin
            se_sel  = 3'b001;
            alu_sel = 1'b1;
         end
         OP_BRANCH: se_sel = 3'b010;
         default: ;
      endcase
      case (opcode)
         OP_R:     alu_op = {funct7[5], funct3};
         OP_OPIMM: alu_op = {(funct3 == 3'b101) & funct7[5], funct3};
         OP_BRANCH: begin
            case (funct3)
               3'b000, 3'b001: alu_op = ALU_SUB;
               3'b100, 3'b101: alu_op = ALU_SLT;
               3'b110, 3'b111: alu_op = ALU_SLTU;
               default:        alu_op = ALU_ADD;
            endcase
         end
         default: ;
      endcase
      case (funct3)
         3'b000:         taken = (alu_result == 32'd0);
         3'b001:         taken = (alu_result != 32'd0);
         3'b100, 3'b110: taken = alu_result[0];
         3'b101, 3'b111: taken = ~alu_result[0];
         default:        taken = 1'b0;
      endcase
   end

   // Next state and per-state control outputs
   always_comb begin
      state_d   = state_q;
      mux_se    = 3'b000;
      mux_alu   = 1'b0;
      we_alu    = 1'b0;
      aluop     = 4'b0000;
      we_result = 1'b0;
      we_dmem   = 1'b0;
      we_pc     = 1'b0;
      we_store  = 1'b0;
      mux_store = 2'b00;
      mux_load  = 3'b000;
      mux_wb    = 3'b000;
      we_rf     = 1'b0;
      mux_pc    = 1'b0;
      mux_jalr  = 1'b0;
      case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            we_alu  = 1'b1;
            mux_se  = se_sel;
            mux_alu = alu_sel;
            state_d = S_EXECUTE;
            case (opcode)
               OP_LUI: begin
                  mux_wb  = 3'b011;
                  we_rf   = 1'b1;
                  we_pc   = 1'b1;
                  state_d = S_FETCH;
               end
               OP_AUIPC: begin
                  mux_wb  = 3'b100;
                  we_rf   = 1'b1;
                  we_pc   = 1'b1;
                  state_d = S_FETCH;
               end
               OP_JAL: begin
                  mux_wb  = 3'b010;
                  we_rf   = 1'b1;
                  mux_pc  = 1'b1;
                  we_pc   = 1'b1;
                  state_d = S_FETCH;
               end
               OP_R, OP_OPIMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: ;
               default: begin
                  we_pc   = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_EXECUTE: begin
            mux_se  = se_sel;
            mux_alu = alu_sel;
            aluop   = alu_op;
            state_d = S_FETCH;
            case (opcode)
               OP_R, OP_OPIMM:    state_d = S_WB;
               OP_LOAD, OP_STORE: state_d = S_MEM;
               OP_BRANCH: begin
                  mux_pc = taken;
                  we_pc  = 1'b1;
               end
               OP_JALR: begin
                  mux_wb   = 3'b010;
                  we_rf    = 1'b1;
                  mux_jalr = 1'b1;
                  mux_pc   = 1'b1;
                  we_pc    = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            mux_se  = se_sel;
            mux_alu = alu_sel;
            aluop   = alu_op;
            state_d = S_FETCH;
            case (opcode)
               OP_STORE: begin
                  we_result = 1'b1;
                  we_dmem   = 1'b1;
                  we_store  = 1'b1;
                  mux_store = funct3[1:0];
                  we_pc     = 1'b1;
               end
               OP_LOAD: begin
                  we_result = 1'b1;
                  state_d   = S_WB;
               end
               default: ;
            endcase
         end
         S_WB: begin
            mux_se  = se_sel;
            mux_alu = alu_sel;
            aluop   = alu_op;
            state_d = S_FETCH;
            case (opcode)
               OP_R, OP_OPIMM: begin
                  we_result = 1'b1;
                  we_rf     = 1'b1;
                  we_pc     = 1'b1;
               end
               OP_LOAD: begin
                  mux_wb   = 3'b001;
                  mux_load = funct3;
                  we_rf    = 1'b1;
                  we_pc    = 1'b1;
               end
               default: ;
            endcase
         end
         default: state_d = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus randomized
// instructions compared cycle by cycle against a per-instruction behavioural model.
module tb_control_unit;

   typedef struct packed {
      logic [2:0] mux_se;
      logic       mux_alu;
      logic       we_alu;
      logic [3:0] aluop;
      logic       we_result;
      logic       we_dmem;
      logic       we_pc;
      logic       we_store;
      logic [1:0] mux_store;
      logic [2:0] mux_load;
      logic [2:0] mux_wb;
      logic       we_rf;
      logic       mux_pc;
      logic       mux_jalr;
   } out_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] alu_result;
   logic [2:0]  mux_se;
   logic        mux_alu, we_alu;
   logic [3:0]  aluop;
   logic        we_result, we_dmem, we_pc, we_store;
   logic [1:0]  mux_store;
   logic [2:0]  mux_load, mux_wb;
   logic        we_rf, mux_pc, mux_jalr;

   int checks = 0;
   int errors = 0;

   control_unit dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .alu_result(alu_result), .mux_se(mux_se), .mux_alu(mux_alu), .we_alu(we_alu),
      .aluop(aluop), .we_result(we_result), .we_dmem(we_dmem), .we_pc(we_pc),
      .we_store(we_store), .mux_store(mux_store), .mux_load(mux_load), .mux_wb(mux_wb),
      .we_rf(we_rf), .mux_pc(mux_pc), .mux_jalr(mux_jalr)
   );

   always #5 clk = ~clk;

   function automatic out_t sample();
      out_t o;
      o = '{mux_se, mux_alu, we_alu, aluop, we_result, we_dmem, we_pc, we_store,
            mux_store, mux_load, mux_wb, we_rf, mux_pc, mux_jalr};
      return o;
   endfunction

   // Instruction length in cycles, FETCH included
   function automatic int ref_len(input logic [6:0] op);
      case (op)
         7'b0110111, 7'b0010111, 7'b1101111: return 2;
         7'b1100011, 7'b1100111:             return 3;
         7'b0110011, 7'b0010011, 7'b0100011: return 4;
         7'b0000011:                         return 5;
         default:                            return 2;
      endcase
   endfunction

   // Expected outputs in cycle 'cyc' of an instruction (cycle 0 is FETCH)
   function automatic out_t ref_out(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [31:0] res,
                                    input int cyc);
      out_t o;
      int   n;
      bit   last, tk;
      int   sres;
      o    = '0;
      n    = ref_len(op);
      last = (cyc == n - 1);
      if (cyc == 0) return o;
      o.we_alu = (cyc == 1);
      o.we_pc  = last;
      case (op)
         7'b0010011, 7'b0000011, 7'b1100111: o.mux_alu = 1'b1;
         7'b0100011: begin o.mux_alu = 1'b1; o.mux_se = 3'd1; end
         7'b1100011: o.mux_se = 3'd2;
         default: ;
      endcase
      if (cyc >= 2) begin
         case (op)
            7'b0110011: o.aluop = {f7[5], f3};
            7'b0010011: o.aluop = {f3 == 3'd5 && f7[5], f3};
            7'b1100011: o.aluop = (f3 < 3'd2) ? 4'b1000 : (f3 < 3'd6) ? 4'b0010 : 4'b0011;
            default:    o.aluop = 4'b0000;
         endcase
      end
      sres = int'(res[0]);
      case (f3)
         3'd0: tk = (res == 0);
         3'd1: tk = (res != 0);
         3'd4, 3'd6: tk = (sres == 1);
         default: tk = (sres == 0);
      endcase
      case (op)
         7'b0110111: if (last) begin o.mux_wb = 3'd3; o.we_rf = 1; end
         7'b0010111: if (last) begin o.mux_wb = 3'd4; o.we_rf = 1; end
         7'b1101111: if (last) begin o.mux_wb = 3'd2; o.we_rf = 1; o.mux_pc = 1; end
         7'b1100011: if (last) o.mux_pc = tk;
         7'b1100111: if (last) begin
            o.mux_wb = 3'd2; o.we_rf = 1; o.mux_jalr = 1; o.mux_pc = 1;
         end
         7'b0110011, 7'b0010011: if (last) begin o.we_result = 1; o.we_rf = 1; end
         7'b0100011: if (last) begin
            o.we_result = 1; o.we_dmem = 1; o.we_store = 1; o.mux_store = f3[1:0];
         end
         7'b0000011: begin
            if (cyc == 3) o.we_result = 1;
            if (last) begin o.mux_wb = 3'd1; o.mux_load = f3; o.we_rf = 1; end
         end
         default: ;
      endcase
      return o;
   endfunction

   task automatic apply(input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] res);
      opcode = op; funct3 = f3; funct7 = f7; alu_result = res;
   endtask

   task automatic test_reset();
      out_t got;
      rst = 1'b1;
      apply(7'b0110011, 3'd0, 7'd0, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== out_t'(0)) begin
         errors++;
         $display("FAIL reset_outputs got %h want %h", got, out_t'(0));
      end
      rst = 1'b0;
   endtask

   task automatic test_alu_store();
      logic [6:0] ops[3]  = '{7'b0110011, 7'b0010011, 7'b0100011};
      logic [2:0] f3s[3]  = '{3'd0, 3'd4, 3'd1};
      out_t got, exp;
      for (int i = 0; i < 3; i++) begin
         apply(ops[i], f3s[i], 7'd0, $urandom);
         for (int k = 0; k < ref_len(ops[i]); k++) begin
            got = sample();
            exp = ref_out(ops[i], f3s[i], 7'd0, alu_result, k);
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL alu_store op%0d cyc%0d got %h want %h", i, k, got, exp);
            end
            @(posedge clk); @(negedge clk);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] ops[3] = '{7'b0110111, 7'b0010111, 7'b1101111};
      out_t got, exp;
      for (int i = 0; i < 3; i++) begin
         apply(ops[i], 3'($urandom), 7'($urandom), $urandom);
         for (int k = 0; k < 2; k++) begin
            got = sample();
            exp = ref_out(ops[i], funct3, funct7, alu_result, k);
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL back_to_back op%0d cyc%0d got %h want %h", i, k, got, exp);
            end
            @(posedge clk); @(negedge clk);
         end
      end
   endtask

   task automatic test_branch();
      logic [31:0] res[2] = '{32'd0, 32'd5};
      out_t got, exp;
      for (int i = 0; i < 2; i++) begin
         apply(7'b1100011, 3'd0, 7'd0, res[i]);
         for (int k = 0; k < 3; k++) begin
            got = sample();
            exp = ref_out(7'b1100011, 3'd0, 7'd0, res[i], k);
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL beq res%0d cyc%0d got %h want %h", res[i], k, got, exp);
            end
            if (k == 2) begin
               checks++;
               if (mux_pc !== (i == 0)) begin
                  errors++;
                  $display("FAIL beq_taken res%0d got %b want %b", res[i], mux_pc, i == 0);
               end
            end
            @(posedge clk); @(negedge clk);
         end
      end
   endtask

   task automatic test_load_abort();
      out_t got, exp;
      apply(7'b0000011, 3'd2, 7'd0, $urandom);
      for (int k = 0; k < 3; k++) begin
         got = sample();
         exp = ref_out(opcode, funct3, funct7, alu_result, k);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL lw_pre_abort cyc%0d got %h want %h", k, got, exp);
         end
         if (k < 2) begin @(posedge clk); @(negedge clk); end
      end
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      got = sample();
      checks++;
      if (got !== out_t'(0)) begin
         errors++;
         $display("FAIL lw_abort got %h want %h", got, out_t'(0));
      end
      @(posedge clk); @(negedge clk);
      for (int k = 1; k < 5; k++) begin
         got = sample();
         exp = ref_out(opcode, funct3, funct7, alu_result, k);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL lw_full cyc%0d got %h want %h", k, got, exp);
         end
         @(posedge clk); @(negedge clk);
      end
   endtask

   task automatic test_random();
      logic [6:0] ops[12] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                              7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                              7'b0010111, 7'b0001111, 7'b1110011, 7'b1111111};
      logic [2:0] bf3[6]  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      logic [6:0] op;
      logic [2:0] f3;
      logic [31:0] res;
      out_t got, exp;
      for (int i = 0; i < 60; i++) begin
         op  = ops[$urandom_range(11)];
         f3  = (op == 7'b1100011) ? bf3[$urandom_range(5)] : 3'($urandom);
         case ($urandom_range(2))
            0:       res = 32'd0;
            1:       res = 32'($urandom_range(1));
            default: res = $urandom;
         endcase
         apply(op, f3, 7'($urandom), res);
         for (int k = 0; k < ref_len(op); k++) begin
            got = sample();
            exp = ref_out(op, f3, funct7, res, k);
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL random i%0d op%b f3%0d cyc%0d got %h want %h",
                        i, op, f3, k, got, exp);
            end
            @(posedge clk); @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu_store();
      test_back_to_back();
      test_branch();
      test_load_abort();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
